// File: rtl/capture_seq_pkg.sv
// Shared definitions for the frame capture sequencer.
// Holds the FSM state type, the parameter defaults for frame geometry and
// drain length, and the widths of the line, frame and drain counters.
package capture_seq_pkg;

    localparam int FRAME_LINES_DEF  = 480;
    localparam int DRAIN_CYCLES_DEF = 64;

    localparam int LINE_W      = 12;
    localparam int FRAME_CNT_W = 16;
    localparam int DRAIN_W     = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_SOF,
        S_CAPTURE,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/line_frame_counter.sv
// Edge detection on the sensor frame/line valid strobes plus line counting.
// Ports:
//   clk, rst   - pixel clock, async active-high reset
//   fval, lval - registered sensor frame-valid / line-valid
//   count_en   - count line starts only while this is high
//   fval_rise  - frame-valid 0->1 seen this cycle
//   fval_fall  - frame-valid 1->0 seen this cycle
//   line_cnt   - saturating count of line-valid rising edges in this frame
module line_frame_counter
    import capture_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              fval,
    input  logic              lval,
    input  logic              count_en,
    output logic              fval_rise,
    output logic              fval_fall,
    output logic [LINE_W-1:0] line_cnt
);

    logic fval_q;
    logic lval_q;
    logic lval_rise;

    assign fval_rise = fval & ~fval_q;
    assign fval_fall = ~fval & fval_q;
    assign lval_rise = lval & ~lval_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fval_q   <= 1'b0;
            lval_q   <= 1'b0;
            line_cnt <= '0;
        end else begin
            fval_q <= fval;
            lval_q <= lval;
            // A new frame always starts counting from zero; the count
            // holds at all-ones rather than wrapping back to a legal value.
            if (fval_rise) begin
                line_cnt <= '0;
            end else if (count_en && lval_rise && (line_cnt != '1)) begin
                line_cnt <= line_cnt + LINE_W'(1);
            end
        end
    end

endmodule

// File: rtl/frame_capture_seq.sv
// Frame capture sequencer: arms a downstream capture unit on frame
// boundaries, counts lines per frame, reserves a drain window after each
// frame for the SDRAM write FIFO, and counts completed frames.
// Ports:
//   iCLK, iRST    - pixel clock, async active-high reset
//   iFVAL, iLVAL  - registered sensor frame-valid / line-valid
//   iRUN          - level request for continuous capture
//   iSNAP         - one-cycle request for a single frame
//   iSTOP         - one-cycle abort request
//   oSTART, oEND  - one-cycle start / end pulses to the capture unit
//   oWR_LOAD      - one-cycle write-FIFO address reload pulse
//   oBUSY         - high whenever not idle
//   oFRAME_DONE   - one-cycle pulse on the last drain cycle
//   oFRAME_CNT    - completed frame count (wraps)
//   oLINE_ERR     - sticky: some frame had the wrong number of lines
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | nothing requested
// S_ARM      | capture requested, waiting for the sensor to leave a frame
// S_WAIT_SOF | capture unit started, waiting for frame-valid to rise
// S_CAPTURE  | inside a frame, counting lines
// S_DRAIN    | frame over, giving the write FIFO DRAIN_CYCLES to flush
module frame_capture_seq
    import capture_seq_pkg::*;
#(
    parameter int FRAME_LINES  = FRAME_LINES_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic                   iFVAL,
    input  logic                   iLVAL,
    input  logic                   iRUN,
    input  logic                   iSNAP,
    input  logic                   iSTOP,
    output logic                   oSTART,
    output logic                   oEND,
    output logic                   oWR_LOAD,
    output logic                   oBUSY,
    output logic                   oFRAME_DONE,
    output logic [FRAME_CNT_W-1:0] oFRAME_CNT,
    output logic                   oLINE_ERR
);

    state_t              state;
    logic                one_shot;
    logic [DRAIN_W-1:0]  drain_tmr;
    logic                fval_rise;
    logic                fval_fall;
    logic [LINE_W-1:0]   line_cnt;

    line_frame_counter u_line_frame_counter (
        .clk       (iCLK),
        .rst       (iRST),
        .fval      (iFVAL),
        .lval      (iLVAL),
        .count_en  (state == S_CAPTURE),
        .fval_rise (fval_rise),
        .fval_fall (fval_fall),
        .line_cnt  (line_cnt)
    );

    assign oBUSY = (state != S_IDLE);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state       <= S_IDLE;
            one_shot    <= 1'b0;
            drain_tmr   <= '0;
            oSTART      <= 1'b0;
            oEND        <= 1'b0;
            oWR_LOAD    <= 1'b0;
            oFRAME_DONE <= 1'b0;
            oFRAME_CNT  <= '0;
            oLINE_ERR   <= 1'b0;
        end else begin
            oSTART      <= 1'b0;
            oEND        <= 1'b0;
            oWR_LOAD    <= 1'b0;
            oFRAME_DONE <= 1'b0;

            case (state)
                S_IDLE: begin
                    // Stop wins over a simultaneous snapshot or run request.
                    if (!iSTOP && (iRUN || iSNAP)) begin
                        state     <= S_ARM;
                        one_shot  <= iSNAP;
                        oLINE_ERR <= 1'b0;
                    end
                end

                S_ARM: begin
                    if (iSTOP) begin
                        state    <= S_IDLE;
                        oEND     <= 1'b1;
                        one_shot <= 1'b0;
                    end else if (!iFVAL) begin
                        // Only start between frames so a partial frame is
                        // never handed to the capture unit.
                        state    <= S_WAIT_SOF;
                        oWR_LOAD <= 1'b1;
                        oSTART   <= 1'b1;
                    end
                end

                S_WAIT_SOF: begin
                    if (iSTOP) begin
                        state    <= S_IDLE;
                        oEND     <= 1'b1;
                        one_shot <= 1'b0;
                    end else if (fval_rise) begin
                        state <= S_CAPTURE;
                    end
                end

                S_CAPTURE: begin
                    // A stop mid-frame lets the frame finish, then idles.
                    if (iSTOP) begin
                        one_shot <= 1'b1;
                    end
                    if (fval_fall) begin
                        state     <= S_DRAIN;
                        drain_tmr <= DRAIN_W'(DRAIN_CYCLES - 1);
                        if (line_cnt != LINE_W'(FRAME_LINES)) begin
                            oLINE_ERR <= 1'b1;
                        end
                        if (one_shot || iSTOP || !iRUN) begin
                            oEND <= 1'b1;
                        end
                        // With a one-cycle drain the entry cycle is also
                        // the last one.
                        if (DRAIN_CYCLES == 1) begin
                            oFRAME_DONE <= 1'b1;
                            oFRAME_CNT  <= oFRAME_CNT + FRAME_CNT_W'(1);
                        end
                    end
                end

                S_DRAIN: begin
                    if (iSTOP) begin
                        one_shot <= 1'b1;
                    end
                    // Outputs are registered, so raising done when the
                    // timer reads 1 makes the pulse coincide with the
                    // final drain cycle (timer reading 0).
                    if (drain_tmr == DRAIN_W'(1)) begin
                        oFRAME_DONE <= 1'b1;
                        oFRAME_CNT  <= oFRAME_CNT + FRAME_CNT_W'(1);
                    end
                    if (drain_tmr == '0) begin
                        state    <= (iRUN && !one_shot && !iSTOP) ? S_ARM : S_IDLE;
                        one_shot <= 1'b0;
                    end else begin
                        drain_tmr <= drain_tmr - DRAIN_W'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_capture_seq.sv
module tb_frame_capture_seq;

    localparam int FL = 480;
    localparam int DC = 64;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        fval = 1'b0;
    logic        lval = 1'b0;
    logic        run  = 1'b0;
    logic        snap = 1'b0;
    logic        stop = 1'b0;
    logic        start_p, end_p, wr_load, busy, done, err;
    logic [15:0] cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int n_start = 0, n_load = 0, n_end = 0, n_done = 0;
    int last_done = -1, last_end = -1;

    // Reference model state: frames completed and sticky line error.
    int   exp_cnt = 0;
    logic exp_err = 1'b0;

    frame_capture_seq #(.FRAME_LINES(FL), .DRAIN_CYCLES(DC)) dut (
        .iCLK        (clk),
        .iRST        (rst),
        .iFVAL       (fval),
        .iLVAL       (lval),
        .iRUN        (run),
        .iSNAP       (snap),
        .iSTOP       (stop),
        .oSTART      (start_p),
        .oEND        (end_p),
        .oWR_LOAD    (wr_load),
        .oBUSY       (busy),
        .oFRAME_DONE (done),
        .oFRAME_CNT  (cnt),
        .oLINE_ERR   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (start_p) n_start++;
        if (wr_load) n_load++;
        if (end_p) begin n_end++; last_end = cyc; end
        if (done) begin n_done++; last_done = cyc; end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One sensor frame with random line timing. Optionally pulses stop or
    // drops run during a given line. Returns the cycle at which fval fell.
    task automatic frame(input int nlines, input int stop_line, input int drop_line,
                         output int fall_cyc);
        fval = 1'b0;
        lval = 1'b0;
        tick(4);
        fval = 1'b1;
        tick(2);
        for (int l = 0; l < nlines; l++) begin
            lval = 1'b1;
            tick($urandom_range(2, 1));
            lval = 1'b0;
            if (l == drop_line) run = 1'b0;
            if (l == stop_line) stop = 1'b1;
            tick(1);
            stop = 1'b0;
            tick($urandom_range(1, 0));
        end
        tick(1);
        fval = 1'b0;
        fall_cyc = cyc;
    endtask

    task automatic drain_check(input int fall_cyc, input int nlines,
                               input logic exp_end, input logic exp_busy);
        int d0;
        int e0;
        d0 = n_done;
        e0 = n_end;
        tick(DC + 1);
        exp_cnt = (exp_cnt + 1) & 16'hFFFF;
        if (nlines != FL) exp_err = 1'b1;
        chk("done_pulses", n_done - d0, 1);
        chk("done_latency", last_done - fall_cyc, DC);
        chk("end_pulses", n_end - e0, {31'd0, exp_end});
        if (exp_end) chk("end_latency", last_end - fall_cyc, 1);
        chk("busy_after_drain", {31'd0, busy}, {31'd0, exp_busy});
        chk("frame_cnt", {16'd0, cnt}, exp_cnt);
        chk("line_err", {31'd0, err}, {31'd0, exp_err});
        tick(5);
    endtask

    initial begin
        int fc, s0, l0, e0, d0, nl;

        // Reset state
        tick(3);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_start", {31'd0, start_p}, 0);
        chk("rst_end", {31'd0, end_p}, 0);
        chk("rst_load", {31'd0, wr_load}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_cnt", {16'd0, cnt}, 0);
        chk("rst_err", {31'd0, err}, 0);
        rst = 1'b0;
        tick(2);

        // Continuous run, three good frames, run dropped mid third frame
        s0 = n_start; l0 = n_load;
        run = 1'b1;
        frame(FL, -1, -1, fc);  drain_check(fc, FL, 1'b0, 1'b1);
        frame(FL, -1, -1, fc);  drain_check(fc, FL, 1'b0, 1'b1);
        frame(FL, -1, 200, fc); drain_check(fc, FL, 1'b1, 1'b0);
        chk("run_starts", n_start - s0, 3);
        chk("run_loads", n_load - l0, 3);

        // Single snapshot
        snap = 1'b1; tick(1); snap = 1'b0;
        frame(FL, -1, -1, fc); drain_check(fc, FL, 1'b1, 1'b0);
        s0 = n_start;
        frame(FL, -1, -1, fc); tick(DC + 6);
        chk("idle_no_capture_cnt", {16'd0, cnt}, exp_cnt);
        chk("idle_no_start", n_start - s0, 0);

        // Short frame sets sticky error which survives a good frame
        run = 1'b1; exp_err = 1'b0;
        frame(FL - 1, -1, -1, fc); drain_check(fc, FL - 1, 1'b0, 1'b1);
        frame(FL, -1, 100, fc);    drain_check(fc, FL, 1'b1, 1'b0);

        // Stop while armed (fval high): error clears on IDLE->ARM
        fval = 1'b1; tick(1);
        s0 = n_start;
        run = 1'b1; tick(2);
        exp_err = 1'b0;
        chk("err_clear_on_arm", {31'd0, err}, {31'd0, exp_err});
        chk("arm_busy", {31'd0, busy}, 1);
        e0 = n_end; d0 = n_done;
        stop = 1'b1; run = 1'b0; tick(1); stop = 1'b0; tick(2);
        chk("arm_stop_busy", {31'd0, busy}, 0);
        chk("arm_stop_end", n_end - e0, 1);
        chk("arm_stop_no_done", n_done - d0, 0);
        chk("arm_waits_fval_low", n_start - s0, 0);

        // Stop while waiting for start of frame
        fval = 1'b0; run = 1'b1; tick(3);
        chk("wsof_start", n_start - s0, 1);
        e0 = n_end;
        stop = 1'b1; run = 1'b0; tick(1); stop = 1'b0; tick(2);
        chk("wsof_stop_busy", {31'd0, busy}, 0);
        chk("wsof_stop_end", n_end - e0, 1);

        // Stop and snapshot together while idle
        s0 = n_start;
        stop = 1'b1; snap = 1'b1; tick(1); stop = 1'b0; snap = 1'b0; tick(3);
        chk("stop_snap_busy", {31'd0, busy}, 0);
        chk("stop_snap_no_start", n_start - s0, 0);

        // Stop during capture: frame completes then idles despite run
        run = 1'b1; exp_err = 1'b0;
        frame(FL, 240, -1, fc); drain_check(fc, FL, 1'b1, 1'b0);
        stop = 1'b1; run = 1'b0; tick(1); stop = 1'b0; tick(2);

        // Random line counts around the nominal value
        run = 1'b1; exp_err = 1'b0;
        for (int f = 0; f < 3; f++) begin
            nl = FL - 2 + $urandom_range(4, 0);
            frame(nl, -1, (f == 2) ? 50 : -1, fc);
            drain_check(fc, nl, (f == 2), (f != 2));
        end

        // Reset released in the middle of a frame
        rst = 1'b1; fval = 1'b1; run = 1'b1; tick(2);
        exp_cnt = 0; exp_err = 1'b0;
        rst = 1'b0;
        s0 = n_start;
        for (int l = 0; l < 8; l++) begin
            lval = 1'b1; tick(2); lval = 1'b0; tick(2);
        end
        chk("midframe_no_start", n_start - s0, 0);
        chk("midframe_cnt", {16'd0, cnt}, 0);
        frame(FL, -1, -1, fc); drain_check(fc, FL, 1'b0, 1'b1);

        // Reset pulse during drain clears everything at once
        frame(FL, -1, -1, fc);
        tick(20);
        #2;
        rst = 1'b1;
        #1;
        chk("drain_rst_busy", {31'd0, busy}, 0);
        chk("drain_rst_cnt", {16'd0, cnt}, 0);
        chk("drain_rst_err", {31'd0, err}, 0);
        chk("drain_rst_done", {31'd0, done}, 0);
        chk("drain_rst_pulses", {29'd0, start_p, end_p, wr_load}, 0);
        run = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("post_rst_busy", {31'd0, busy}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
